// File: rtl/gnrc_gray2bin_pipe.sv
// gnrc_gray2bin_pipe
//   Pipelined gray-to-binary decoder. The MSB-down XOR prefix chain is cut
//   into STAGES register slices of CHUNK = ceil(N/STAGES) bits each. Every
//   slice has a valid/ready handshake, and the pipeline has no skid buffer.
//
// Parameters
//   N       code width (>= 1)
//   STAGES  number of register stages (1..N), equal to the unstalled latency
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset (clears valids and data)
//   flush_i      synchronous flush (clears valids, blocks input this cycle)
//   in_valid_i   input word valid
//   in_ready_o   input accepted this cycle when in_valid_i is also high
//   in_gray_i    gray-coded input word
//   out_valid_o  output word valid
//   out_ready_i  downstream accepts the output word
//   out_bin_o    decoded binary word
//   busy_o       at least one stage holds a word
module gnrc_gray2bin_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_gray_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_bin_o,
  output logic         busy_o
);

  localparam int CHUNK = (N + STAGES - 1) / STAGES;

  logic [STAGES-1:0]        vld_q, vld_d;
  logic [STAGES-1:0][N-1:0] data_q, data_d;
  logic [STAGES-1:0][N-1:0] dec;
  logic [STAGES-1:0]        src_vld;
  logic [STAGES:0]          acc;

  // Per-stage decode slice. Bits above HI arrive already binary, bits below
  // LO stay gray for later stages. A slice with HI < 0 resolves nothing and
  // the stage degenerates to a plain register.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI = N - 1 - k * CHUNK;
    localparam int LO = HI - CHUNK + 1;

    logic [N-1:0] src;
    logic [N-1:0] slice;

    if (k == 0) begin : g_first
      assign src        = in_gray_i;
      assign src_vld[k] = in_valid_i;
    end else begin : g_next
      assign src        = data_q[k-1];
      assign src_vld[k] = vld_q[k-1];
    end

    // Only the nearest resolved bit above the slice feeds its XOR chain.
    always_comb begin
      slice = src;
      for (int i = N - 2; i >= 0; i--) begin
        if (i >= LO && i <= HI) slice[i] = slice[i+1] ^ src[i];
      end
    end

    assign dec[k] = slice;
  end

  // A stage can take a word when it is empty or its word moves on.
  always_comb begin
    acc[STAGES] = out_ready_i;
    for (int k = STAGES - 1; k >= 0; k--) acc[k] = !vld_q[k] | acc[k+1];
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (acc[k] && src_vld[k]) begin
        vld_d[k]  = 1'b1;
        data_d[k] = dec[k];
      end else if (acc[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o  = acc[0] & ~flush_i;
  assign out_valid_o = vld_q[STAGES-1];
  assign out_bin_o   = data_q[STAGES-1];
  assign busy_o      = |vld_q;

endmodule
